// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: pixel-rate enable, raster counters, one-pixel-ahead
// pixel request and a two-stage registered sync/de/rgb output pipeline.
// Start and stop are frame-aligned and follow the level of 'enable'.
module vga_scan_ctrl #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        enable,
   input  logic [15:0] pix_rgb,
   output logic        pix_ce,
   output logic        pix_req,
   output logic [11:0] req_x,
   output logic [11:0] req_y,
   output logic        frame_start,
   output logic        busy,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_de,
   output logic [15:0] vga_rgb
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] CE_LAST = 12'(CLK_DIV - 1);
   localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
   localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
   localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic SYNC_ACT  = (SYNC_POL != 0);
   localparam logic SYNC_IDLE = ~SYNC_ACT;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOP_PEND = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [11:0] cnt;
   logic [11:0] h;
   logic [11:0] v;
   logic        act;
   logic        hs_raw;
   logic        vs_raw;
   logic        frame_end;
   logic        stop_now;
   logic        s1_act;
   logic        s1_hs;
   logic        s1_vs;

   // Raster decode, pixel enable and request outputs from the current counters
   always_comb begin
      act         = (h < H_ACT) && (v < V_ACT);
      hs_raw      = (h >= HS_BEG) && (h < HS_END);
      vs_raw      = (v >= VS_BEG) && (v < VS_END);
      busy        = (state != IDLE);
      pix_ce      = busy && (cnt == CE_LAST);
      pix_req     = pix_ce && act;
      req_x       = h;
      req_y       = v;
      frame_start = pix_ce && (h == '0) && (v == '0);
      frame_end   = pix_ce && (h == H_LAST) && (v == V_LAST);
   end

   // Next-state logic; a re-raised enable in STOP_PEND wins over the frame-end exit
   always_comb begin
      state_nxt = state;
      stop_now  = 1'b0;
      case (state)
         IDLE:      if (enable) state_nxt = RUN;
         RUN:       if (!enable) state_nxt = STOP_PEND;
         STOP_PEND: begin
            if (enable) begin
               state_nxt = RUN;
            end else if (frame_end) begin
               state_nxt = IDLE;
               stop_now  = 1'b1;
            end
         end
         default:   state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   // Clock divider and raster counters; held at zero while idle
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n || state == IDLE || stop_now) begin
         cnt <= '0;
         h   <= '0;
         v   <= '0;
      end else begin
         cnt <= (cnt == CE_LAST) ? '0 : cnt + 12'd1;
         if (pix_ce) begin
            if (h == H_LAST) begin
               h <= '0;
               v <= (v == V_LAST) ? '0 : v + 12'd1;
            end else begin
               h <= h + 12'd1;
            end
         end
      end
   end

   // Two-stage output pipeline advanced on pix_ce; pix_rgb joins at the second stage
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n || stop_now) begin
         s1_act  <= 1'b0;
         s1_hs   <= 1'b0;
         s1_vs   <= 1'b0;
         vga_de  <= 1'b0;
         vga_hs  <= SYNC_IDLE;
         vga_vs  <= SYNC_IDLE;
         vga_rgb <= '0;
      end else if (pix_ce) begin
         s1_act  <= act;
         s1_hs   <= hs_raw;
         s1_vs   <= vs_raw;
         vga_de  <= s1_act;
         vga_hs  <= s1_hs ? SYNC_ACT : SYNC_IDLE;
         vga_vs  <= s1_vs ? SYNC_ACT : SYNC_IDLE;
         vga_rgb <= s1_act ? pix_rgb : '0;
      end
   end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a cycle-indexed raster model predicts every output
// from the elapsed run time; an upstream model answers each pixel request.
module tb_vga_scan_ctrl;

   localparam int D     = 2;
   localparam int HA    = 8;
   localparam int HF    = 2;
   localparam int HS    = 3;
   localparam int HB    = 2;
   localparam int VA    = 4;
   localparam int VF    = 1;
   localparam int VS    = 2;
   localparam int VB    = 1;
   localparam int HT    = HA + HF + HS + HB;
   localparam int VT    = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        enable;
   logic [15:0] pix_rgb;
   logic        pix_ce;
   logic        pix_req;
   logic [11:0] req_x;
   logic [11:0] req_y;
   logic        frame_start;
   logic        busy;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_de;
   logic [15:0] vga_rgb;

   always #5 sys_clk = ~sys_clk;

   vga_scan_ctrl #(
      .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .pix_rgb(pix_rgb),
      .pix_ce(pix_ce), .pix_req(pix_req), .req_x(req_x), .req_y(req_y),
      .frame_start(frame_start), .busy(busy), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_de(vga_de), .vga_rgb(vga_rgb)
   );

   int          n_vec = 0;
   int          n_err = 0;
   bit          m_busy;
   bit          m_pend;
   int          m_c;
   int          cyc = 0;
   int          last_fs = -1;
   logic [15:0] salt;

   function automatic logic [11:0] h_of(input int n);
      return 12'(n % HT);
   endfunction

   function automatic logic [11:0] v_of(input int n);
      return 12'((n / HT) % VT);
   endfunction

   function automatic bit act_of(input int n);
      return (n % HT) < HA && ((n / HT) % VT) < VA;
   endfunction

   function automatic bit hsync_of(input int n);
      return (n % HT) >= HA + HF && (n % HT) < HA + HF + HS;
   endfunction

   function automatic bit vsync_of(input int n);
      return ((n / HT) % VT) >= VA + VF && ((n / HT) % VT) < VA + VF + VS;
   endfunction

   // Upstream source: coordinates packed as {y[3:0], x}, scrambled per run
   function automatic logic [15:0] src_pix(input logic [11:0] x, input logic [11:0] y);
      return {y[3:0], x} ^ salt;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Run-time model: busy flag, pending-stop flag and cycles since busy rose
   task automatic model_step(input bit en, input bit rn);
      bit ce;
      int n;
      if (!rn) begin
         m_busy = 0; m_pend = 0; m_c = 0;
      end else if (!m_busy) begin
         if (en) begin m_busy = 1; m_pend = 0; m_c = 0; end
      end else begin
         ce = ((m_c + 1) % D) == 0;
         n  = (m_c + 1) / D - 1;
         if (m_pend && !en && ce && (n % FRAME) == FRAME - 1) begin
            m_busy = 0; m_pend = 0; m_c = 0;
         end else begin
            m_pend = !en;
            m_c++;
         end
      end
   endtask

   task automatic check_all();
      bit          e_ce = 0, e_req = 0, e_fs = 0, e_de = 0, e_hs = 1, e_vs = 1;
      logic [15:0] e_rgb = '0;
      logic [11:0] ex = '0, ey = '0;
      int          n, e, no;
      if (m_busy) begin
         e_ce = ((m_c + 1) % D) == 0;
         n    = (m_c + 1) / D - 1;
         if (e_ce) begin
            e_req = act_of(n);
            e_fs  = (n % FRAME) == 0;
            ex    = h_of(n);
            ey    = v_of(n);
         end
         e = m_c / D;
         if (e >= 2) begin
            no    = e - 2;
            e_de  = act_of(no);
            e_hs  = !hsync_of(no);
            e_vs  = !vsync_of(no);
            e_rgb = e_de ? src_pix(h_of(no), v_of(no)) : 16'h0;
         end
      end
      chk("busy", busy, m_busy);
      chk("pix_ce", pix_ce, e_ce);
      chk("pix_req", pix_req, e_req);
      chk("frame_start", frame_start, e_fs);
      chk("vga_hs", vga_hs, e_hs);
      chk("vga_vs", vga_vs, e_vs);
      chk("vga_de", vga_de, e_de);
      chk("vga_rgb", vga_rgb, e_rgb);
      if (e_req) begin
         chk("req_x", req_x, ex);
         chk("req_y", req_y, ey);
      end
   endtask

   // One clock: predict, clock, answer the request, compare
   task automatic tick();
      bit          req, ce_b;
      logic [11:0] rx, ry;
      req  = pix_req;
      ce_b = pix_ce;
      rx   = req_x;
      ry   = req_y;
      model_step(enable, sys_rst_n);
      @(posedge sys_clk);
      #1;
      cyc++;
      if (req)       pix_rgb = src_pix(rx, ry);
      else if (ce_b) pix_rgb = 16'($urandom);
      check_all();
      if (!m_busy) last_fs = -1;
      if (frame_start) begin
         if (last_fs >= 0) chk("frame_gap", cyc - last_fs, D * FRAME);
         last_fs = cyc;
      end
   endtask

   function automatic bit ce_at(input int pix);
      return m_busy && ((m_c + 1) % D) == 0 && (((m_c + 1) / D - 1) % FRAME) == pix;
   endfunction

   int  cnt_req, cnt_de, cnt_hs, cnt_vs, cnt_fs;
   bit  found;
   int  target;

   initial begin
      salt      = 16'($urandom);
      sys_rst_n = 1'b0;
      enable    = 1'b0;
      pix_rgb   = '0;
      m_busy = 0; m_pend = 0; m_c = 0;
      @(posedge sys_clk);
      #1;

      // Reset, then idle with enable low
      repeat (3) tick();
      sys_rst_n = 1'b1;
      repeat (50) tick();

      // Start: busy next edge, first pix_ce/frame_start one divider period on
      enable = 1'b1;
      tick();
      chk("start_busy", busy, 1);
      chk("start_no_ce", pix_ce, 0);
      tick();
      chk("first_ce", pix_ce, 1);
      chk("first_fs", frame_start, 1);

      // Steady frames, plus per-frame totals over one full frame window
      repeat (2 * D * FRAME) tick();
      cnt_req = 0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
      repeat (D * FRAME) begin
         tick();
         cnt_req += int'(pix_req);
         cnt_fs  += int'(frame_start);
         cnt_de  += int'(vga_de);
         cnt_hs  += int'(!vga_hs);
         cnt_vs  += int'(!vga_vs);
      end
      chk("req_per_frame", cnt_req, HA * VA);
      chk("fs_per_frame", cnt_fs, 1);
      chk("de_cycles", cnt_de, D * HA * VA);
      chk("hs_cycles", cnt_hs, D * HS * VT);
      chk("vs_cycles", cnt_vs, D * VS * HT);

      // Stop: drop enable at pixel (5,2); scan completes the frame then idles
      found = 0;
      for (int i = 0; i < 2 * D * FRAME && !found; i++) begin
         if (ce_at(2 * HT + 5)) found = 1;
         else tick();
      end
      chk("reach_5_2", found, 1);
      enable = 1'b0;
      for (int i = 0; i < 2 * D * FRAME && m_busy; i++) tick();
      chk("stopped_busy", busy, 0);
      repeat (20) tick();

      // Restart, then brief enable drops that end before frame end
      enable = 1'b1;
      repeat (D * FRAME + 10) tick();
      for (int k = 0; k < 4; k++) begin
         target = $urandom_range(0, 49);
         found  = 0;
         for (int i = 0; i < 2 * D * FRAME && !found; i++) begin
            if (ce_at(target)) found = 1;
            else tick();
         end
         chk("reach_drop", found, 1);
         enable = 1'b0;
         repeat ($urandom_range(1, 60)) tick();
         enable = 1'b1;
         repeat (D * FRAME) tick();
         chk("glitch_busy", busy, 1);
      end

      // Reset mid-frame during active video with enable held high
      found = 0;
      for (int i = 0; i < 2 * D * FRAME && !found; i++) begin
         if (vga_de && m_busy && ((m_c / D) - 2) % HT == 3) found = 1;
         else tick();
      end
      chk("reach_active", found, 1);
      sys_rst_n = 1'b0;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_hs", vga_hs, 1);
      chk("rst_de", vga_de, 0);
      chk("rst_rgb", vga_rgb, 0);
      sys_rst_n = 1'b1;
      tick();
      chk("restart_busy", busy, 1);
      tick();
      chk("restart_fs", frame_start, 1);
      chk("restart_x", req_x, 0);
      chk("restart_y", req_y, 0);
      repeat (D * FRAME + 20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

VGA scan controller that sequences the pixel pipeline for the display path. It runs on the system clock and derives a pixel-rate clock enable internally, so no divided clock is needed. It generates horizontal and vertical counters, requests each active pixel from the upstream source one pixel period ahead, and drives registered hsync, vsync, data-enable and RGB. Start and stop are frame-aligned and controlled by a level `enable`.

## Interface
Parameters:
- `CLK_DIV`, 2: sys_clk cycles per pixel, ≥1.
- `H_ACTIVE`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: sync active level. 0 = active-low, so the inactive level is 1.

Ports:
- `sys_clk` in 1: system clock. Single clock domain.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `enable` in 1: run request, level-sensitive.
- `pix_rgb` in 16: RGB565 pixel answering the previous `pix_req`.
- `pix_ce` out 1: one-cycle pixel-rate enable.
- `pix_req` out 1: pixel request. Always coincident with `pix_ce`.
- `req_x` out 12: requested column, valid with `pix_req`.
- `req_y` out 12: requested row, valid with `pix_req`.
- `frame_start` out 1: one-cycle pulse at pixel (0,0).
- `busy` out 1: high when state ≠ IDLE.
- `vga_hs` out 1: registered horizontal sync.
- `vga_vs` out 1: registered vertical sync.
- `vga_de` out 1: registered data enable.
- `vga_rgb` out 16: registered pixel data.

## Operation
Derived constants:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
- V_TOTAL is the vertical equivalent.
- All counters are 12 bits. Counter arithmetic wraps explicitly at TOTAL−1 and never relies on natural overflow.

States:
- IDLE: divider `cnt` = 0, `h` = `v` = 0, no `pix_ce`. Outputs held at idle levels: hs/vs at the inactive level, de = 0, rgb = 0.
- RUN: IDLE & `enable` → RUN on the next edge. RUN & !`enable` → STOP_PEND.
- STOP_PEND: the scan continues unchanged.
  - `enable` high → RUN. This takes priority over every other transition.
  - Otherwise, on the `pix_ce` where (`h`,`v`) = (H_TOTAL−1, V_TOTAL−1) → IDLE. On that edge `h`, `v`, `cnt` and the pipeline are cleared, and outputs take idle levels.

Pixel enable:
- In RUN/STOP_PEND, `cnt` counts 0..CLK_DIV−1 and wraps.
- `pix_ce` = (`cnt` == CLK_DIV−1) while not IDLE.
- With CLK_DIV = 1, `pix_ce` is high every non-IDLE cycle.

Counters:
- On `pix_ce`, `h` increments; at H_TOTAL−1 it wraps to 0 and `v` increments.
- `v` wraps to 0 at V_TOTAL−1.

Raw decode from (`h`,`v`):
- act = `h` < H_ACTIVE && `v` < V_ACTIVE.
- hs_raw active for H_ACTIVE+H_FP ≤ `h` < H_ACTIVE+H_FP+H_SYNC.
- vs_raw active for V_ACTIVE+V_FP ≤ `v` < V_ACTIVE+V_FP+V_SYNC. vs_raw depends only on `v`.

Request:
- `pix_req` = `pix_ce` && act.
- `req_x` = `h`, `req_y` = `v`.
- `frame_start` = `pix_ce` && `h` == 0 && `v` == 0 (not IDLE).

Pipeline, advanced only on `pix_ce`:
- Stage 1 captures {act, hs_raw, vs_raw}.
- The output stage captures stage 1: `vga_de` = s1.act, and `vga_hs`/`vga_vs` = active level when s1.hs/s1.vs is set.
- `vga_rgb` = s1.act ? `pix_rgb` : 0.
- `pix_rgb` is therefore sampled exactly one `pix_ce` after its `pix_req`. Upstream has CLK_DIV cycles to respond.

## Timing
Reset values (all outputs, state IDLE):
- `vga_hs` = `vga_vs` = ~SYNC_POL.
- `vga_de` = 0, `vga_rgb` = 0.
- `pix_ce` = `pix_req` = `frame_start` = `busy` = 0.

Reset behaviour:
- `sys_rst_n` low at any point, including mid-frame, forces reset values at the next edge.
- Enable is ignored while reset is low.

Start and stop latency:
- `enable` sampled high in IDLE gives `busy` = 1 on the next edge.
- The first `pix_ce` and `frame_start` follow CLK_DIV cycles later.

Pipeline latency:
- Outputs lag the counters by exactly 2 `pix_ce` edges.
- hs, vs, de and rgb stay mutually aligned, with no skew between them.

Outputs between enables:
- Outputs change only on a `pix_ce` edge, or on the IDLE-entry edge.

Stop boundary:
- The last two pixel periods of the final frame are vertical back porch.
- Forcing idle levels at IDLE entry is therefore required and produces no visible glitch.

## Test plan
Use bench parameters: CLK_DIV = 2, H = 8/2/3/2 (H_TOTAL = 15), V = 4/1/2/1 (V_TOTAL = 8), SYNC_POL = 0.

1. Reset then idle: hold `enable` = 0 for 50 cycles → hs = vs = 1, de = 0, rgb = 0, `busy` = 0, no `pix_ce`.
2. Start: raise `enable` → `busy` = 1 next edge; first `pix_ce` and `frame_start` 2 cycles later. `pix_ce` period = 2 cycles. `frame_start` repeats every 240 cycles.
3. Line/frame timing: for each line, `vga_de` is high for 8 `pix_ce` and `vga_hs` is low for 3 `pix_ce`, starting 10 pixels after the de rise. `vga_vs` is low for exactly 2 lines (30 `pix_ce`). `pix_req` appears 32 times per frame.
4. Data path: a model returns `pix_rgb` = {`req_y`[3:0], `req_x`[11:0]} one `pix_ce` after each request → the `vga_rgb` sequence while de is high equals the requested coordinates in raster order. `vga_rgb` = 0 while de is low.
5. Stop/restart: drop `enable` at pixel (5,2) → the scan continues to (14,7), then enters IDLE with `busy` = 0. Dropping `enable` and re-raising it before frame end → no break in `frame_start` spacing.
6. Reset mid-frame: assert `sys_rst_n` = 0 for 1 cycle during active video with `enable` = 1 → all outputs at reset values on the next edge. Restart begins at (0,0) with `frame_start`.
